// File: rtl/dds_pkg.sv
// Shared definitions for the DDS key controller.
//   wave_t    : waveform codes driven on wave_sel
//   FCW_W     : default frequency-control-word width
//   STEP_NUM  : number of tuning steps (indices 0..STEP_NUM-1)
//   fcw_step(): FCW increment for each step index (1 Hz .. 100 kHz at 50 MHz, 2^32)
package dds_pkg;

  localparam int FCW_W    = 32;
  localparam int STEP_NUM = 6;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_t;

  // Indices 6/7 cannot be reached by the step counter; they fall back to the
  // smallest step so an upset never produces a large jump.
  function automatic logic [FCW_W-1:0] fcw_step(input logic [2:0] idx);
    case (idx)
      3'd0:    fcw_step = 32'd86;
      3'd1:    fcw_step = 32'd859;
      3'd2:    fcw_step = 32'd8_590;
      3'd3:    fcw_step = 32'd85_899;
      3'd4:    fcw_step = 32'd858_993;
      3'd5:    fcw_step = 32'd8_589_935;
      default: fcw_step = 32'd86;
    endcase
  endfunction

endpackage

// File: rtl/dds_fcw_sat.sv
// Registered frequency control word with saturating add/subtract.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : add / subtract step this cycle (both together = no change)
//   step       : current tuning step
//   fcw        : registered frequency control word
//   changed    : combinational, high when fcw will change at the next edge
module dds_fcw_sat #(
  parameter int               FCW_W    = 32,
  parameter logic [FCW_W-1:0] FCW_INIT = 32'd85_899,
  parameter logic [FCW_W-1:0] FCW_MIN  = 32'd86,
  parameter logic [FCW_W-1:0] FCW_MAX  = 32'd858_993_459
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic [FCW_W-1:0] step,
  output logic [FCW_W-1:0] fcw,
  output logic             changed
);

  logic [FCW_W:0]   sum;
  logic [FCW_W:0]   floor;
  logic [FCW_W-1:0] fcw_nxt;

  // One extra bit on both compares so neither the sum nor MIN+step can wrap.
  always_comb begin
    sum     = {1'b0, fcw} + {1'b0, step};
    floor   = {1'b0, FCW_MIN} + {1'b0, step};
    fcw_nxt = fcw;
    if (inc && !dec) begin
      fcw_nxt = (sum > {1'b0, FCW_MAX}) ? FCW_MAX : sum[FCW_W-1:0];
    end else if (dec && !inc) begin
      fcw_nxt = ({1'b0, fcw} < floor) ? FCW_MIN : (fcw - step);
    end
  end

  assign changed = (fcw_nxt != fcw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcw <= FCW_INIT;
    else        fcw <= fcw_nxt;
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// DDS configuration controller driven by debounced single-cycle key pulses.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key_wave/key_step  : advance waveform / tuning step
//   key_up/key_down    : fcw +/- step with saturation at FCW_MIN/FCW_MAX
//   key_amp            : advance amplitude shift (only with DDS_AMP_CTRL_EN)
//   wave_sel, step_idx, fcw, amp_shift : registered configuration
//   cfg_upd            : one-cycle strobe, high when any output just changed
// Build option: define DDS_AMP_CTRL_EN to build the amplitude counter;
// otherwise key_amp is ignored and amp_shift is tied to 0.
module dds_key_ctrl
  import dds_pkg::*;
#(
  parameter int               FCW_W     = dds_pkg::FCW_W,
  parameter logic [FCW_W-1:0] FCW_INIT  = 32'd85_899,
  parameter logic [FCW_W-1:0] FCW_MIN   = 32'd86,
  parameter logic [FCW_W-1:0] FCW_MAX   = 32'd858_993_459,
  parameter logic [2:0]       STEP_INIT = 3'd3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_wave,
  input  logic             key_step,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_amp,
  output logic [1:0]       wave_sel,
  output logic [2:0]       step_idx,
  output logic [FCW_W-1:0] fcw,
  output logic [1:0]       amp_shift,
  output logic             cfg_upd
);

  wave_t            wave;
  logic [FCW_W-1:0] step;
  logic             fcw_chg;
  logic             amp_chg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave <= WAVE_SINE;
    end else if (key_wave) begin
      case (wave)
        WAVE_SINE:     wave <= WAVE_SQUARE;
        WAVE_SQUARE:   wave <= WAVE_TRIANGLE;
        WAVE_TRIANGLE: wave <= WAVE_SAW;
        default:       wave <= WAVE_SINE;
      endcase
    end
  end

  assign wave_sel = wave;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_idx <= STEP_INIT;
    end else if (key_step) begin
      step_idx <= (step_idx >= 3'(STEP_NUM - 1)) ? 3'd0 : step_idx + 3'd1;
    end
  end

  // up/down use the step in force before this cycle's key_step takes effect.
  assign step = FCW_W'(fcw_step(step_idx));

  dds_fcw_sat #(
    .FCW_W    (FCW_W),
    .FCW_INIT (FCW_INIT),
    .FCW_MIN  (FCW_MIN),
    .FCW_MAX  (FCW_MAX)
  ) u_fcw_sat (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .inc     (key_up),
    .dec     (key_down),
    .step    (step),
    .fcw     (fcw),
    .changed (fcw_chg)
  );

`ifdef DDS_AMP_CTRL_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   amp_shift <= 2'd0;
    else if (key_amp) amp_shift <= amp_shift + 2'd1;
  end

  assign amp_chg = key_amp;
`else
  logic unused_key_amp;

  assign unused_key_amp = key_amp;
  assign amp_shift      = 2'd0;
  assign amp_chg        = 1'b0;
`endif

  // wave, step and amp keys always move their counters; fcw only when not saturated.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cfg_upd <= 1'b0;
    else            cfg_upd <= key_wave | key_step | fcw_chg | amp_chg;
  end

endmodule
